elut_bank_cfg: RTL and testbench

ELUT_BANK_CFG -- requirements
Module: elut_bank_cfg

---
 rtl/elut_bank_cfg_pkg.sv | 13 +
 rtl/elut_cell.sv | 30 +++
 rtl/elut_bank_cfg.sv | 92 +++++++++
 tb/tb_elut_bank_cfg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/elut_bank_cfg_pkg.sv
// Shared defaults and FSM encoding for the serially configured LUT bank.
package elut_bank_cfg_pkg;

  localparam int unsigned ELUT_K_DEF       = 6;
  localparam int unsigned ELUT_NUM_LUT_DEF = 4;
  localparam int unsigned ELUT_REG_OUT_DEF = 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } elut_state_e;

endpackage

// File: rtl/elut_cell.sv
// Single 2^K x 1 LUT storage: one synchronous write port, one asynchronous read port.
module elut_cell #(
  parameter int unsigned K = 6
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [K-1:0] i_waddr,
  input  logic         i_wdata,
  input  logic [K-1:0] i_raddr,
  output logic         o_rdata
);

  // No reset so the array maps onto distributed/MLAB RAM.
`ifdef PLATFORM_XILINX
  (* ram_style = "distributed" *) logic [2**K-1:0] r_mem;
`elsif PLATFORM_ALTERA
  (* ramstyle = "MLAB" *) logic [2**K-1:0] r_mem;
`else
  logic [2**K-1:0] r_mem;
`endif

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/elut_bank_cfg.sv
// Bank of NUM_LUT K-input LUTs loaded from one serial stream, LUT 0 address 0 first.
module elut_bank_cfg
  import elut_bank_cfg_pkg::*;
#(
  parameter int unsigned K       = ELUT_K_DEF,
  parameter int unsigned NUM_LUT = ELUT_NUM_LUT_DEF,
  parameter int unsigned REG_OUT = ELUT_REG_OUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic                 cfg_data,
  output logic                 cfg_ready,
  input  logic                 cfg_restart,
  output logic                 cfg_done,
  input  logic [NUM_LUT*K-1:0] rd_addr,
  output logic [NUM_LUT-1:0]   dpo,
  output logic [NUM_LUT-1:0]   qdpo
);

  localparam int unsigned LW = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1;

  elut_state_e         r_state;
  elut_state_e         w_state_nxt;
  logic [LW-1:0]       r_lut;
  logic [K-1:0]        r_addr;
  logic                w_accept;
  logic                w_addr_last;
  logic                w_last;
  logic [NUM_LUT-1:0]  w_rd;

  assign cfg_ready = (r_state == ST_LOAD);
  assign cfg_done  = (r_state == ST_RUN);

  // A restart in the same cycle discards the offered bit.
  assign w_accept    = cfg_valid && cfg_ready && !cfg_restart;
  assign w_addr_last = (r_addr == '1);
  assign w_last      = w_accept && w_addr_last && (r_lut == LW'(NUM_LUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (w_last)      w_state_nxt = ST_RUN;
      ST_RUN:  if (cfg_restart) w_state_nxt = ST_LOAD;
      default:                  w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_lut   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (cfg_restart) begin
        r_lut  <= '0;
        r_addr <= '0;
      end else if (w_accept) begin
        r_addr <= r_addr + K'(1);
        if (w_addr_last) begin
          r_lut <= w_last ? '0 : r_lut + LW'(1);
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_LUT; n++) begin : g_lut
    elut_cell #(.K(K)) u_cell (
      .clk     (clk),
      .i_we    (w_accept && (r_lut == LW'(n))),
      .i_waddr (r_addr),
      .i_wdata (cfg_data),
      .i_raddr (rd_addr[n*K +: K]),
      .o_rdata (w_rd[n])
    );
  end

  assign dpo = (r_state == ST_RUN) ? w_rd : '0;

  if (REG_OUT != 0) begin : g_qdpo
    logic [NUM_LUT-1:0] r_qdpo;
    always_ff @(posedge clk) begin
      if (rst) r_qdpo <= '0;
      else     r_qdpo <= dpo;
    end
    assign qdpo = r_qdpo;
  end else begin : g_no_qdpo
    assign qdpo = '0;
  end

endmodule

// File: tb/tb_elut_bank_cfg.sv
// Directed self-checking bench for elut_bank_cfg (default build plus a K=2 single-LUT build).
module tb_elut_bank_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_data, cfg_restart;
  logic        cfg_ready, cfg_done;
  logic [23:0] rd_addr;
  logic [3:0]  dpo, qdpo;

  logic        s_valid, s_data, s_restart;
  logic        s_ready, s_done;
  logic [1:0]  s_rd_addr;
  logic [0:0]  s_dpo, s_qdpo;

  int unsigned n_tot = 0;
  int unsigned n_bad = 0;
  bit          mdl [4][64];

  always #5 clk = ~clk;

  elut_bank_cfg u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_restart(cfg_restart), .cfg_done(cfg_done),
    .rd_addr(rd_addr), .dpo(dpo), .qdpo(qdpo)
  );

  elut_bank_cfg #(.K(2), .NUM_LUT(1), .REG_OUT(0)) u_small (
    .clk(clk), .rst(rst), .cfg_valid(s_valid), .cfg_data(s_data),
    .cfg_ready(s_ready), .cfg_restart(s_restart), .cfg_done(s_done),
    .rd_addr(s_rd_addr), .dpo(s_dpo), .qdpo(s_qdpo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all ones; 1: LUT0 bit = addr[0]; 2: all zeros; 3: LUT2 addr 63 only
  function automatic bit patbit(input int mode, input int idx);
    int l = idx / 64;
    int a = idx % 64;
    case (mode)
      0:       return 1'b1;
      1:       return (l == 0) && a[0];
      3:       return (l == 2) && (a == 63);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_dpo(input logic [23:0] ra);
    logic [3:0] e;
    for (int n = 0; n < 4; n++) e[n] = mdl[n][ra[n*6 +: 6]];
    return e;
  endfunction

  // Feeds nbits bits of a pattern; rnd gates cfg_valid at random.
  task automatic load_bits(input int mode, input int nbits, input bit rnd);
    int acc = 0;
    int cyc = 0;
    while (acc < nbits && cyc < 4000) begin
      cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = cfg_valid ? patbit(mode, acc) : 1'($urandom_range(0, 1));
      rd_addr   = 24'($urandom);
      #1;
      chk("done_early", cfg_done, 0);
      if (cfg_valid && acc == 255) chk("dpo_final_write", dpo, 0);
      tick();
      if (cfg_valid) begin
        mdl[acc / 64][acc % 64] = cfg_data;
        acc++;
      end
      cyc++;
    end
    cfg_valid = 1'b0;
    chk("load_bound", acc, nbits);
  endtask

  task automatic expect_run();
    chk("done_after_load", cfg_done, 1);
    chk("ready_in_run", cfg_ready, 0);
  endtask

  task automatic restart();
    cfg_restart = 1'b1;
    tick();
    cfg_restart = 1'b0;
    chk("restart_done", cfg_done, 0);
    chk("restart_ready", cfg_ready, 1);
    chk("restart_dpo", dpo, 0);
  endtask

  // Random read sweep; qdpo is checked after rd_addr has already moved on.
  task automatic read_sweep(input int n);
    logic [3:0] prev;
    for (int i = 0; i < n; i++) begin
      rd_addr = (i == 0) ? '0 : (i == 1) ? '1 : 24'($urandom);
      #1;
      if (i > 0) chk("qdpo_lag", qdpo, prev);
      chk("dpo_read", dpo, exp_dpo(rd_addr));
      prev = exp_dpo(rd_addr);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 0; cfg_data = 0; cfg_restart = 0; rd_addr = '0;
    s_valid = 0; s_data = 0; s_restart = 0; s_rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", cfg_ready, 1);
    chk("rst_done", cfg_done, 0);
    chk("rst_dpo", dpo, 0);
    chk("rst_qdpo", qdpo, 0);

    // all ones, constant valid
    load_bits(0, 256, 0);
    expect_run();
    read_sweep(12);

    // LUT0 = addr[0]
    restart();
    load_bits(1, 256, 0);
    expect_run();
    rd_addr = {18'd0, 6'd5}; #1;
    chk("p1_addr5", dpo, 4'b0001);
    tick();
    rd_addr = {6'd5, 6'd5, 6'd5, 6'd4}; #1;
    chk("p1_addr4", dpo, 4'b0000);
    chk("p1_qdpo_addr5", qdpo, 4'b0001);
    read_sweep(8);

    // random valid, all ones
    restart();
    load_bits(0, 256, 1);
    expect_run();
    read_sweep(8);

    // abort after 100 bits via rst (with a bit offered in the rst cycle), then zeros
    restart();
    load_bits(0, 100, 0);
    rst = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1; cfg_restart = 1'b1;
    tick();
    rst = 1'b0; cfg_valid = 1'b0; cfg_restart = 1'b0;
    chk("mid_rst_done", cfg_done, 0);
    chk("mid_rst_qdpo", qdpo, 0);
    load_bits(2, 256, 0);
    expect_run();
    read_sweep(8);

    // restart in LOAD with a bit offered: it is discarded, counters cleared
    restart();
    load_bits(0, 10, 0);
    cfg_restart = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    tick();
    cfg_restart = 1'b0; cfg_valid = 1'b0;
    chk("load_restart_ready", cfg_ready, 1);
    load_bits(3, 256, 0);
    expect_run();
    for (int a = 0; a < 64; a++) begin
      rd_addr = {4{6'(a)}}; #1;
      chk("p3_sweep", dpo, (a == 63) ? 4'b0100 : 4'b0000);
    end

    // small build: K=2, one LUT, no output register
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s_rst_ready", s_ready, 1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = (i == 0 || i == 3);
      #1;
      chk("s_done_early", s_done, 0);
      tick();
    end
    s_valid = 1'b0;
    chk("s_done", s_done, 1);
    for (int a = 0; a < 4; a++) begin
      s_rd_addr = 2'(a); #1;
      chk("s_dpo", s_dpo, (a == 0 || a == 3) ? 1'b1 : 1'b0);
      tick();
      chk("s_qdpo", s_qdpo, 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
